alu_src_sequencer: RTL and testbench
====================================

# alu_src_sequencer

Multi-cycle controller for the processor's ALU operand-B select path. It accepts one decoded instruction at a time over a valid/ready handshake. It then drives the operand-B select code, the 8-bit immediate and the shift direction for as many ALU passes as the instruction needs: one pass for register ops and 8-bit LI, N single-bit passes for shift-by-N, and low-then-high passes for 16-bit LI. It sits between the decode stage and the ALU/operand-B mux, and it tells the register-file writeback when each pass result is valid.

## Interface
Parameters:
- `SHAMT_W`, default 3: shift-amount width; maximum shift is 2^SHAMT_W-1.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous, active-low.
- `instr_valid`: input, 1 bit. Decode presents an instruction.
- `instr_ready`: output, 1 bit. Sequencer can accept; equals 1 exactly in IDLE.
- `opcode`: input, 3 bits. 0=REG, 1=SHL, 2=SHR, 3=LI, 4=LI16, 5-7 illegal.
- `shamt`: input, SHAMT_W bits. Shift count for SHL/SHR.
- `imm16`: input, 16 bits. Immediate; LI uses [7:0], LI16 uses all bits.
- `hold`: input, 1 bit. Pipeline stall; freezes the sequencer.
- `alu_src_sel`: output, 2 bits. Operand-B select: 0=register value, 1=shift word/bit, 2=immediate, 3=zero.
- `li_imm`: output, 8 bits. Immediate byte fed to select code 2.
- `shift_dir`: output, 1 bit. 0=left, 1=right.
- `alu_en`: output, 1 bit. ALU pass active this cycle.
- `wb_en`: output, 1 bit. Writeback the ALU result this cycle.
- `wb_hi`: output, 1 bit. Writeback targets the high byte; LI16 second pass only.
- `done`: output, 1 bit. One-cycle pulse in the final cycle of an instruction.
- `err`: output, 1 bit. One-cycle pulse with `done` for an illegal opcode.

## Operation
- States: IDLE, EXEC, SHIFT, LI_LO, LI_HI, FINISH.
- Capture happens on `instr_valid && instr_ready` at a rising edge. `opcode`, `shamt` and `imm16` are registered at that edge and are ignored at all other times.
- Transitions out of IDLE, by opcode:
  - REG, LI → EXEC
  - SHL/SHR with shamt≠0 → SHIFT
  - SHL/SHR with shamt=0, or illegal opcode → FINISH
  - LI16 → LI_LO
- EXEC (1 cycle): `alu_src_sel`=0 for REG, 2 for LI (`li_imm`=imm[7:0]); `alu_en`=`wb_en`=`done`=1; next state IDLE.
- SHIFT: loads down-counter = shamt. Each cycle drives `alu_src_sel`=1, `shift_dir`, `alu_en`=`wb_en`=1 and decrements the counter. `done`=1 in the cycle the counter equals 1, and that cycle's next state is IDLE.
- LI_LO: `alu_src_sel`=2, `li_imm`=imm[7:0], `alu_en`=`wb_en`=1, `wb_hi`=0; next state LI_HI.
- LI_HI: `li_imm`=imm[15:8], `wb_hi`=1, `done`=1; next state IDLE.
- FINISH (1 cycle): `alu_src_sel`=3, `alu_en`=`wb_en`=0, `done`=1; `err`=1 only for an illegal opcode. Next state IDLE.
- In IDLE: `alu_src_sel`=3, `li_imm`=0, and `alu_en`/`wb_en`/`wb_hi`/`done`/`err`=0.
- `hold`=1: state, counter and captured operands are frozen. `alu_src_sel`/`li_imm`/`shift_dir` are held, while `alu_en`, `wb_en`, `done` and `err` are forced to 0. No capture occurs in IDLE while `hold`=1, and `instr_ready` stays 1.

## Timing
- Reset values: state IDLE; `instr_ready`=1; `alu_src_sel`=3; `li_imm`=0; `shift_dir`=0; `alu_en`/`wb_en`/`wb_hi`/`done`/`err`=0; counter 0.
- All outputs except `instr_ready` are registered.
- First active cycle is the cycle after capture.
- Latency from capture to the `done` cycle:
  - REG, LI, zero-shift, illegal: 1 cycle
  - SHL/SHR: shamt cycles
  - LI16: 2 cycles
- Throughput: the sequencer returns to IDLE after `done`, so the maximum rate is one REG/LI instruction per 2 cycles.
- `rst_n` low mid-instruction aborts immediately. No further `wb_en` occurs and the partial result is discarded.
- `hold` asserted in the `done` cycle postpones `done` until `hold` falls.

## Configuration
- `ALU_SEQ_LI16_EN` defined: opcode 4 executes the two-pass LI_LO/LI_HI sequence.
- Undefined: the LI_LO and LI_HI states are not compiled, `wb_hi` is tied 0, and opcode 4 is treated as illegal (FINISH with `err`=1).

## Test plan
- Reset then REG, capture at cycle 0: cycle 1 has `alu_src_sel`=0 and `alu_en`=`wb_en`=`done`=1; cycle 2 is IDLE with `instr_ready`=1.
- SHR with shamt=5: five consecutive cycles with `alu_src_sel`=1, `shift_dir`=1 and `wb_en`=1; `done` only in the 5th; shamt=0 gives 1 FINISH cycle with no `wb_en`.
- LI16 imm16=0xA55A (macro defined): `li_imm`=0x5A with `wb_hi`=0, then 0xA5 with `wb_hi`=1 and `done`. With the macro undefined: `done`=`err`=1 and no `wb_en`.
- SHL with shamt=3 and `hold` high for 2 cycles after the first pass: exactly 3 `wb_en` pulses total; outputs held and `alu_en`=0 during hold.
- `rst_n` pulsed low during the second SHIFT cycle of shamt=7: outputs asynchronously return to reset values and no further `wb_en` occurs.
- Opcode 6: one cycle with `alu_src_sel`=3 and `done`=`err`=1; the next instruction is accepted normally.

Source files
------------

// File: rtl/alu_src_sequencer.sv
// Operand-B select sequencer: turns one decoded instruction into one or more ALU passes.
// Optional macro ALU_SEQ_LI16_EN enables the two-pass 16-bit load-immediate (opcode 4).
module alu_src_sequencer #(
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [2:0]         opcode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [15:0]        imm16,
    input  logic               hold,
    output logic [1:0]         alu_src_sel,
    output logic [7:0]         li_imm,
    output logic               shift_dir,
    output logic               alu_en,
    output logic               wb_en,
    output logic               wb_hi,
    output logic               done,
    output logic               err
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both 1 and hold is 0; instr_ready is 1 exactly in IDLE.

    localparam logic [2:0] OP_REG  = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_LI   = 3'd3;

    localparam logic [1:0] SEL_REG   = 2'd0;
    localparam logic [1:0] SEL_SHIFT = 2'd1;
    localparam logic [1:0] SEL_IMM   = 2'd2;
    localparam logic [1:0] SEL_ZERO  = 2'd3;

`ifdef ALU_SEQ_LI16_EN
    localparam logic [2:0] OP_LI16 = 3'd4;
    localparam logic [2:0] OP_MAX  = 3'd4;
    localparam int         IMM_W   = 16;
`else
    localparam logic [2:0] OP_MAX  = 3'd3;
    localparam int         IMM_W   = 8;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_SHIFT  = 3'd2,
        S_FINISH = 3'd3
`ifdef ALU_SEQ_LI16_EN
        ,
        S_LI_LO  = 3'd4,
        S_LI_HI  = 3'd5
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [IMM_W-1:0]   imm_q, imm_d;

    logic [1:0] sel_q, sel_d;
    logic [7:0] li_q, li_d;
    logic       dir_q, dir_d;
    logic       en_q, en_d;
    logic       wb_q, wb_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

`ifndef ALU_SEQ_LI16_EN
    // Upper immediate byte only matters for the two-pass load.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm16[15:8];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        imm_d   = imm_q;
        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_d  = opcode;
                        imm_d = imm16[IMM_W-1:0];
                        case (opcode)
                            OP_REG, OP_LI: state_d = S_EXEC;
                            OP_SHL, OP_SHR: begin
                                if (shamt != '0) begin
                                    state_d = S_SHIFT;
                                    cnt_d   = shamt;
                                end else begin
                                    state_d = S_FINISH;
                                end
                            end
`ifdef ALU_SEQ_LI16_EN
                            OP_LI16: state_d = S_LI_LO;
`endif
                            default: state_d = S_FINISH;
                        endcase
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - SHAMT_W'(1);
                    end
                end
`ifdef ALU_SEQ_LI16_EN
                S_LI_LO: state_d = S_LI_HI;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the state being entered, so a pass is visible
    // in the cycle after the edge that selects it; hold keeps the data path steady.
`ifdef ALU_SEQ_LI16_EN
    logic hi_q, hi_d;
`endif
    always_comb begin
        sel_d  = sel_q;
        li_d   = li_q;
        dir_d  = dir_q;
        en_d   = 1'b0;
        wb_d   = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
`ifdef ALU_SEQ_LI16_EN
        hi_d   = hi_q;
`endif
        if (!hold) begin
`ifdef ALU_SEQ_LI16_EN
            hi_d = 1'b0;
`endif
            case (state_d)
                S_IDLE: begin
                    sel_d = SEL_ZERO;
                    li_d  = '0;
                end
                S_EXEC: begin
                    sel_d  = (op_d == OP_LI) ? SEL_IMM : SEL_REG;
                    li_d   = (op_d == OP_LI) ? imm_d[7:0] : 8'd0;
                    en_d   = 1'b1;
                    wb_d   = 1'b1;
                    done_d = 1'b1;
                end
                S_SHIFT: begin
                    sel_d  = SEL_SHIFT;
                    dir_d  = (op_d == OP_SHR);
                    en_d   = 1'b1;
                    wb_d   = 1'b1;
                    done_d = (cnt_d == SHAMT_W'(1));
                end
`ifdef ALU_SEQ_LI16_EN
                S_LI_LO: begin
                    sel_d = SEL_IMM;
                    li_d  = imm_d[7:0];
                    en_d  = 1'b1;
                    wb_d  = 1'b1;
                end
                S_LI_HI: begin
                    sel_d  = SEL_IMM;
                    li_d   = imm_d[15:8];
                    en_d   = 1'b1;
                    wb_d   = 1'b1;
                    hi_d   = 1'b1;
                    done_d = 1'b1;
                end
`endif
                S_FINISH: begin
                    sel_d  = SEL_ZERO;
                    li_d   = '0;
                    done_d = 1'b1;
                    err_d  = (op_d > OP_MAX);
                end
                default: begin
                    sel_d = SEL_ZERO;
                    li_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            imm_q   <= '0;
            sel_q   <= SEL_ZERO;
            li_q    <= '0;
            dir_q   <= 1'b0;
            en_q    <= 1'b0;
            wb_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            sel_q   <= sel_d;
            li_q    <= li_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            wb_q    <= wb_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_SEQ_LI16_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hi_q <= 1'b0;
        else        hi_q <= hi_d;
    end
    assign wb_hi = hi_q;
`else
    assign wb_hi = 1'b0;
`endif

    assign instr_ready = (state_q == S_IDLE);
    assign alu_src_sel = sel_q;
    assign li_imm      = li_q;
    assign shift_dir   = dir_q;
    assign alu_en      = en_q;
    assign wb_en       = wb_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Randomised bench for alu_src_sequencer; the reference model expands each instruction
// into its list of ALU passes and replays that list cycle by cycle around hold.
module tb_alu_src_sequencer;

  localparam int SW = 3;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    opcode;
  logic [SW-1:0] shamt;
  logic [15:0]   imm16;
  logic          hold;
  logic [1:0]    alu_src_sel;
  logic [7:0]    li_imm;
  logic          shift_dir;
  logic          alu_en;
  logic          wb_en;
  logic          wb_hi;
  logic          done;
  logic          err;

  alu_src_sequencer #(.SHAMT_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .shamt       (shamt),
    .imm16       (imm16),
    .hold        (hold),
    .alu_src_sel (alu_src_sel),
    .li_imm      (li_imm),
    .shift_dir   (shift_dir),
    .alu_en      (alu_en),
    .wb_en       (wb_en),
    .wb_hi       (wb_hi),
    .done        (done),
    .err         (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] li;
    logic       dir;
    logic       en;
    logic       wb;
    logic       hi;
    logic       done;
    logic       err;
  } out_t;

  out_t exp_q[$];   // passes still to come for the current instruction
  out_t cur;        // what the outputs should show this cycle
  bit   m_busy;
  int   n_cmp;
  int   n_miscmp;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic out_t mk(input logic [1:0] sel, input logic [7:0] li, input logic dir,
                              input logic en, input logic wb, input logic hi,
                              input logic dn, input logic er);
    out_t o;
    o.sel = sel; o.li = li; o.dir = dir; o.en = en;
    o.wb = wb; o.hi = hi; o.done = dn; o.err = er;
    return o;
  endfunction

  // Expand an instruction into the ALU passes it should produce.
  task automatic plan(input logic [2:0] op, input logic [SW-1:0] sh, input logic [15:0] imm);
    case (op)
      3'd0: exp_q.push_back(mk(2'd0, 8'd0, cur.dir, 1, 1, 0, 1, 0));
      3'd1, 3'd2: begin
        if (sh == 0) exp_q.push_back(mk(2'd3, 8'd0, cur.dir, 0, 0, 0, 1, 0));
        else for (int i = 1; i <= int'(sh); i++)
          exp_q.push_back(mk(2'd1, 8'd0, (op == 3'd2), 1, 1, 0, (i == int'(sh)), 0));
      end
      3'd3: exp_q.push_back(mk(2'd2, imm[7:0], cur.dir, 1, 1, 0, 1, 0));
`ifdef ALU_SEQ_LI16_EN
      3'd4: begin
        exp_q.push_back(mk(2'd2, imm[7:0],  cur.dir, 1, 1, 0, 0, 0));
        exp_q.push_back(mk(2'd2, imm[15:8], cur.dir, 1, 1, 1, 1, 0));
      end
`endif
      default: exp_q.push_back(mk(2'd3, 8'd0, cur.dir, 0, 0, 0, 1, 1));
    endcase
  endtask

  task automatic compare();
    chk("instr_ready", 16'(instr_ready), 16'(!m_busy));
    chk("alu_src_sel", 16'(alu_src_sel), 16'(cur.sel));
    chk("alu_en",      16'(alu_en),      16'(cur.en));
    chk("wb_en",       16'(wb_en),       16'(cur.wb));
    chk("wb_hi",       16'(wb_hi),       16'(cur.hi));
    chk("done",        16'(done),        16'(cur.done));
    chk("err",         16'(err),         16'(cur.err));
    if (cur.sel == 2'd2 || !m_busy) chk("li_imm", 16'(li_imm), 16'(cur.li));
    if (cur.sel == 2'd1) chk("shift_dir", 16'(shift_dir), 16'(cur.dir));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, 16'(instr_ready), 16'd1);
    chk({tag, ".sel"},   16'(alu_src_sel), 16'd3);
    chk({tag, ".li"},    16'(li_imm),      16'd0);
    chk({tag, ".dir"},   16'(shift_dir),   16'd0);
    chk({tag, ".flags"}, 16'({alu_en, wb_en, wb_hi, done, err}), 16'd0);
  endtask

  // One clock: advance the model at the rising edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (!m_busy) begin
      if (instr_valid && !hold) begin
        plan(opcode, shamt, imm16);
        cur = exp_q.pop_front();
        m_busy = 1'b1;
      end
    end else if (hold) begin
      cur.en = 1'b0; cur.wb = 1'b0; cur.done = 1'b0; cur.err = 1'b0;
    end else if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
    end else begin
      m_busy = 1'b0;
      cur = mk(2'd3, 8'd0, cur.dir, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    compare();
  endtask

  // ---------------- driver ----------------
  task automatic run_instr(input logic [2:0] op, input logic [SW-1:0] sh, input logic [15:0] imm,
                           input int pre_hold, input logic [7:0] hold_pat, input int hold_pct);
    int guard;
    instr_valid = 1'b1; opcode = op; shamt = sh; imm16 = imm;
    for (int i = 0; i < pre_hold; i++) begin
      hold = 1'b1;
      step();
    end
    hold = 1'b0;
    step();
    instr_valid = 1'b0;
    opcode = 3'($urandom); shamt = SW'($urandom); imm16 = 16'($urandom);
    guard = 0;
    while (m_busy && guard < 200) begin
      hold = (guard < 8 && hold_pat[guard]) || (int'($urandom_range(99)) < hold_pct);
      step();
      guard++;
    end
    hold = 1'b0;
    if (m_busy) chk("timeout", 16'd1, 16'd0);
  endtask

  initial begin
    n_cmp = 0; n_miscmp = 0;
    m_busy = 1'b0;
    cur = mk(2'd3, 8'd0, 1'b0, 0, 0, 0, 0, 0);
    rst_n = 1'b1; instr_valid = 1'b0; opcode = '0; shamt = '0; imm16 = '0; hold = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_async");
    @(posedge clk); @(negedge clk);
    chk_reset("reset_hold");
    rst_n = 1'b1;
    step();

    // directed cases
    run_instr(3'd0, 3'd0, 16'h1234, 0, 8'h00, 0);   // REG
    run_instr(3'd3, 3'd0, 16'h00C3, 0, 8'h00, 0);   // LI
    run_instr(3'd2, 3'd5, 16'h0000, 0, 8'h00, 0);   // SHR 5
    run_instr(3'd2, 3'd0, 16'h0000, 0, 8'h00, 0);   // SHR 0
    run_instr(3'd4, 3'd0, 16'hA55A, 0, 8'h00, 0);   // LI16
    run_instr(3'd1, 3'd3, 16'h0000, 0, 8'h03, 0);   // SHL 3, hold 2 cycles after pass 1
    run_instr(3'd1, 3'd3, 16'h0000, 0, 8'h02, 0);   // hold on the edge into the done cycle
    run_instr(3'd6, 3'd2, 16'hFFFF, 0, 8'h00, 0);   // illegal
    run_instr(3'd0, 3'd1, 16'h0000, 2, 8'h00, 0);   // accepted after illegal, hold at IDLE first
    run_instr(3'd4, 3'd0, 16'h3CC3, 0, 8'h01, 0);   // LI16 with hold between passes

    // reset during the second pass of SHR 7
    instr_valid = 1'b1; opcode = 3'd2; shamt = 3'd7; imm16 = 16'h0;
    step();
    instr_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 chk_reset("abort_async");
    @(posedge clk); @(negedge clk);
    chk_reset("abort_hold");
    rst_n = 1'b1;
    m_busy = 1'b0;
    exp_q.delete();
    cur = mk(2'd3, 8'd0, 1'b0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      run_instr(3'($urandom_range(7)), SW'($urandom), 16'($urandom),
                int'($urandom_range(2)) - 1 > 0 ? 1 : 0, 8'h00, 20);
      if ($urandom_range(3) == 0) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miscmp);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
